// File: rtl/cpu_imem_refill_pkg.sv
// Shared CPU definitions for the cache refill engines: FSM encoding and the
// cache block geometry used by both the instruction memory and its refill.
package cpu_imem_refill_pkg;

  localparam int WORDS = 1024;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_imem_refill.sv
// Cache refill engine: copies one block from main memory into the cache write
// port one word at a time, then holds Done until the request is withdrawn.
module cpu_imem_refill
  import cpu_imem_refill_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        INEED_change_cache,
  input  logic [31:0] INEED_Base_Addr,
  input  logic [31:0] INEED_High_Addr,
  output logic [31:0] INEED_Addr,
  output logic [31:0] INEED_Din,
  output logic        INEED_WE,
  output logic        INEED_Done,
  output logic        MEM_Req,
  output logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_Rdata,
  input  logic        MEM_Ack,
  output state_e      dbg_state
);

  // Memory bus handshake: MEM_Req is held from entry into REQ until the cycle
  // in which MEM_Ack is sampled high; MEM_Rdata is only consumed in that cycle.

  localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(WORDS - 1);

  state_e            state_q, state_d;
  logic [31:0]       cur_q, cur_d;
  logic [31:0]       hi_q, hi_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              inv_q, inv_d;
  logic [31:0]       waddr_q, waddr_d;
  logic [31:0]       din_q, din_d;
  logic              mem_req_q, mem_req_d;
  logic              we_q, we_d;
  logic              done_q, done_d;

  logic              abort_now;
  logic              last_word;

  // A drop seen in the WR cycle itself must stop the engine as well, otherwise
  // it would issue one more read after the requester has gone away.
  assign abort_now = abort_q | ~INEED_change_cache;
  assign last_word = inv_q | (cur_q == hi_q) | (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (INEED_change_cache) state_d = S_REQ;
      S_REQ:  if (MEM_Ack) state_d = S_WR;
      S_WR: begin
        if (abort_now)      state_d = S_IDLE;
        else if (last_word) state_d = S_DONE;
        else                state_d = S_REQ;
      end
      S_DONE: if (!INEED_change_cache) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_d   = cur_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    inv_d   = inv_q;
    waddr_d = waddr_q;
    din_d   = din_q;
    unique case (state_q)
      S_IDLE: begin
        if (INEED_change_cache) begin
          cur_d   = INEED_Base_Addr;
          hi_d    = INEED_High_Addr;
          cnt_d   = '0;
          abort_d = 1'b0;
          inv_d   = INEED_High_Addr < INEED_Base_Addr;
        end
      end
      S_REQ: begin
        abort_d = abort_now;
        if (MEM_Ack) begin
          waddr_d = cur_q;
          din_d   = MEM_Rdata;
        end
      end
      S_WR: begin
        abort_d = abort_now;
        if (!abort_now && !last_word) begin
          cur_d = cur_q + 32'd1;
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_comb begin
    mem_req_d = (state_d == S_REQ);
    we_d      = (state_d == S_WR);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q     <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      inv_q     <= 1'b0;
      waddr_q   <= '0;
      din_q     <= '0;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      inv_q     <= inv_d;
      waddr_q   <= waddr_d;
      din_q     <= din_d;
      mem_req_q <= mem_req_d;
      we_q      <= we_d;
      done_q    <= done_d;
    end
  end

  assign MEM_Req    = mem_req_q;
  assign MEM_Addr   = cur_q;
  assign INEED_WE   = we_q;
  assign INEED_Addr = waddr_q;
  assign INEED_Din  = din_q;
  assign INEED_Done = done_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/cpu_imem_refill.md
# cpu_imem_refill

Instruction-cache refill engine. Sits between the instruction memory's INEED_* miss/refill port and the main-memory read bus. When the instruction memory raises INEED_change_cache, it copies the requested 1K-word block from main memory into the cache's write port, one word at a time. It then signals completion with a level-held INEED_Done handshake.

## Interface
- WORDS, 1024: cache block size in words; the index counter is clog2(WORDS) bits.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- INEED_change_cache  in  1  refill request from the instruction memory (level).
- INEED_Base_Addr  in  32  first word address of the block; sampled at refill start.
- INEED_High_Addr  in  32  last word address of the block; sampled at refill start.
- INEED_Addr  out  32  cache write address; the cache uses bits [9:0].
- INEED_Din  out  32  cache write data.
- INEED_WE  out  1  cache write strobe, one-cycle pulse per word.
- INEED_Done  out  1  refill complete; held until INEED_change_cache falls.
- MEM_Req  out  1  main-memory read request; held until MEM_Ack.
- MEM_Addr  out  32  main-memory word address.
- MEM_Rdata  in  32  read data; valid in the MEM_Ack cycle.
- MEM_Ack  in  1  read acknowledge, one-cycle pulse.

## Operation
- Addresses are word addresses end to end; no byte offset.
- Registers:
  - cur (32): current word address.
  - hi (32): last word address.
  - cnt: words remaining guard.
  - abort (1).
- States and transitions:
  - IDLE: if INEED_change_cache=1, set cur←Base, hi←High, cnt←0, abort←0, go to REQ.
  - REQ: MEM_Req=1, MEM_Addr=cur. On MEM_Ack, capture MEM_Rdata into the Din register, go to WR.
  - WR: INEED_WE=1, INEED_Addr=cur, INEED_Din=captured data.
    - If abort, go to IDLE.
    - Else if cur==hi or cnt==WORDS-1, go to DONE.
    - Else cur←cur+1, cnt←cnt+1, go to REQ.
  - DONE: INEED_Done=1. When INEED_change_cache=0, go to IDLE.
- Abort: INEED_change_cache falling while in REQ or WR sets abort.
  - The outstanding read always completes and its word is written.
  - The engine then returns to IDLE without asserting Done.
  - The bus is never left with a dangling request.
- Malformed block bounds:
  - hi<cur at start: exactly one word (Base) is written, then DONE.
  - hi-Base ≥ WORDS: refill is truncated at WORDS words by the cnt guard.
- Base/High changes after the refill has started are ignored.
- Arithmetic: cur+1 is 32-bit and wraps modulo 2^32 without a flag.

## Timing
- Reset values: every output is 0; state is IDLE.
  - Reset is asynchronous, so MEM_Req and INEED_WE drop immediately on rst=0.
- Request to first MEM_Req: 1 cycle (IDLE samples the request, REQ is entered on the next edge).
- MEM_Ack is accepted in any REQ cycle, including the first. Zero wait state means 2 cycles per word (REQ, WR).
- Full 1024-word refill with zero wait states:
  - INEED_Done rises 1+2·1024 = 2049 cycles after the first cycle INEED_change_cache is sampled high.
- INEED_Done and INEED_change_cache handshake:
  - Done stays high while INEED_change_cache=1.
  - Done falls on the edge after INEED_change_cache=0 is sampled.
  - A new request is accepted no earlier than the cycle after returning to IDLE.
- INEED_WE is high for exactly one cycle per word. INEED_Addr and INEED_Din are stable in that cycle and hold their values afterwards.
- MEM_Addr and MEM_Req change only on clock edges; both are registered outputs.

## Structure
- Shared CPU package holds:
  - the state encoding (IDLE, REQ, WR, DONE);
  - the cache block size constant (1024 words, 10-bit index), shared with the instruction memory.
- Single flat module; no sub-module is warranted.
- A generic data-cache refill would instantiate this same block.

## Test plan
- Zero-wait refill:
  - Stimulus: Base=0x400, High=0x7FF, MEM_Rdata=address, ack every REQ cycle.
  - Required: 1024 WE pulses at addresses 0x400..0x7FF with Din=address; Done at cycle 2049.
- Wait states:
  - Stimulus: ack delayed 3 cycles per word.
  - Required: MEM_Req held for 4 cycles per word; addresses sequential; Done after 1+5·1024 cycles.
- Abort:
  - Stimulus: drop INEED_change_cache in REQ at word 5, ack 2 cycles later.
  - Required: word 5 written; state returns to IDLE; Done never asserted; no further MEM_Req.
- Handshake hold:
  - Stimulus: keep INEED_change_cache high 10 cycles after Done.
  - Required: Done high for all 10 cycles, low 1 cycle after the request drops. Then re-raise the request with Base=0x800: a new refill starts.
- Reset mid-refill:
  - Stimulus: rst=0 at word 300.
  - Required: all outputs 0 asynchronously. After release and a new request, the refill restarts at Base.
- Bounds:
  - Stimulus: High<Base.
  - Required: a single write at Base, then Done.
  - Stimulus: High=Base+2000.
  - Required: exactly 1024 writes, then Done.
